// File: rtl/cache_pkg.sv
// Shared cache constants, refill FSM state type and address field helpers.
// The data way and the cache controller import the same definitions so that
// line geometry is described in exactly one place.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 4;
  localparam int BEAT_W   = 32;
  localparam int BEATS    = 4;
  localparam int LINE_W   = BEATS * BEAT_W;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  // Set index of a byte address: the bits just above the line offset.
  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  // Word position of a byte address within its line (byte bits dropped).
  function automatic logic [CNT_W-1:0] get_word_off(input logic [ADDR_W-1:0] addr);
    return addr[2 +: CNT_W];
  endfunction

endpackage

// File: rtl/cache_refill_unit.sv
// Cache line refill engine: requests a line from memory, assembles four beats
// into a line buffer, forwards the missed word as soon as it arrives and then
// writes the whole line into the data way in a single cycle.
module cache_refill_unit
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                mem_rd_req,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic                mem_rd_gnt,
  input  logic                mem_rvalid,
  input  logic [BEAT_W-1:0]   mem_rdata,
  input  logic                mem_rlast,
  output logic                way_we,
  output logic [INDEX_W-1:0]  way_windex,
  output logic [LINE_W-1:0]   way_wdata,
  output logic                crit_valid,
  output logic [BEAT_W-1:0]   crit_word,
  output logic                refill_done,
  output logic                proto_err
);

  refill_state_t     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_line;
  logic [ADDR_W-1:0] r_addr;
  logic              r_protoErr;

  logic              w_beatAccept;
  logic              w_lastBeat;
  logic              w_isCrit;
  logic              w_unusedAddrBits;

  // Beats only count while receiving; anything on the read channel in IDLE or
  // REQ is noise and must not move the counter or touch the buffer.
  assign w_beatAccept = (r_state == RECV) && mem_rvalid;
  assign w_lastBeat   = (r_cnt == CNT_W'(BEATS - 1));
  assign w_isCrit     = w_beatAccept && (r_cnt == get_word_off(r_addr));

  // Byte-select bits of the miss address never affect a line refill.
  assign w_unusedAddrBits = ^r_addr[1:0];

  // Refill sequencing: latch the miss, wait for grant, collect beats, write.
  // The FSM always takes exactly BEATS beats; a misplaced last marker only
  // raises the sticky protocol error and does not shorten the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_line     <= '0;
      r_addr     <= '0;
      r_protoErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_cnt   <= '0;
            r_line  <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem_rd_gnt) begin
            r_state <= RECV;
          end
        end
        RECV: begin
          if (w_beatAccept) begin
            r_line[r_cnt*BEAT_W +: BEAT_W] <= mem_rdata;
            r_cnt <= r_cnt + 1'b1;
            if (mem_rlast != w_lastBeat) begin
              r_protoErr <= 1'b1;
            end
            if (w_lastBeat) begin
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and memory request outputs; the read address is only driven
  // while the request is outstanding and is line aligned.
  assign req_ready   = (r_state == IDLE);
  assign mem_rd_req  = (r_state == REQ);
  assign mem_rd_addr = mem_rd_req ? {r_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)} : '0;

  // The data way write lasts one cycle; the done pulse lets the controller
  // update the tag in the same cycle the data lands.
  assign way_we      = (r_state == WRITE);
  assign refill_done = (r_state == WRITE);
  assign way_windex  = get_index(r_addr);
  assign way_wdata   = r_line;

  // The missed word goes straight from the memory bus to the pipeline.
  assign crit_valid  = w_isCrit;
  assign crit_word   = w_isCrit ? mem_rdata : '0;

  assign proto_err   = r_protoErr;

endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Upstream neighbour of the cache data way. On a miss it fetches one 128-bit line from memory as four 32-bit beats and assembles them into a line buffer.
- It then issues a single-cycle write (we/windex/wdata) into the data way.
- It forwards the critical (missed) word to the pipeline as soon as that word arrives.
- Tag update stays with the cache controller, which uses the done pulse.

Parameters:
- ADDR_W, 32, byte address width
- INDEX_W, 8, set index width (256 lines)
- BEAT_W, 32, memory beat width
- BEATS, 4, beats per line; line width LINE_W = BEATS*BEAT_W = 128; offset width = 4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  refill request from cache controller
- req_addr  in  ADDR_W  missing byte address
- req_ready  out  1  high only in IDLE
- mem_rd_req  out  1  memory read request, held until granted
- mem_rd_addr  out  ADDR_W  line-aligned address {addr[31:4],4'b0}
- mem_rd_gnt  in  1  memory accepts request
- mem_rvalid  in  1  beat valid
- mem_rdata  in  BEAT_W  beat data
- mem_rlast  in  1  final beat marker
- way_we  out  1  data way write enable
- way_windex  out  INDEX_W  addr[11:4] of latched request
- way_wdata  out  LINE_W  assembled line
- crit_valid  out  1  one-cycle pulse: critical word available
- crit_word  out  BEAT_W  word at offset addr[3:2]
- refill_done  out  1  one-cycle pulse, coincident with way_we
- proto_err  out  1  sticky beat-count/last mismatch flag

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; beat counter=0; line buffer=0; latched addr=0; proto_err=0.
  - All outputs 0 except req_ready=1.
  - Reset mid-operation abandons the refill; no way_we is issued.
- States: IDLE, REQ, RECV, WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr, clear beat counter and line buffer, go to REQ.
- REQ:
  - mem_rd_req=1 and mem_rd_addr valid, driven from the latched address and stable until granted.
  - On mem_rd_gnt, go to RECV.
  - mem_rvalid is ignored in REQ and IDLE.
  - The earliest accepted beat is the cycle after the grant.
- RECV:
  - Each cycle with mem_rvalid, store mem_rdata into line slice [cnt*32 +: 32]. Beat 0 is the lowest word. Increment the 2-bit counter.
  - If cnt == latched addr[3:2]: crit_valid=1 and crit_word=mem_rdata in the same cycle (combinational pass-through), exactly once per refill.
  - Gaps (mem_rvalid=0) hold state.
  - On the beat with cnt==3, go to WRITE.
  - If mem_rlast is not equal to (cnt==3) on any accepted beat, set proto_err. The FSM still completes after exactly 4 beats; an early last is otherwise ignored.
- WRITE, exactly one cycle:
  - way_we=1, way_windex=latched addr[11:4], way_wdata=full buffer, refill_done=1.
  - Next state is IDLE.
- way_wdata and way_windex are registered/held; they are only meaningful when way_we=1.
- req_valid outside IDLE is ignored (req_ready=0); no queuing.
- Latency with immediate grant and back-to-back beats:
  - Request accepted at edge 0; mem_rd_req in cycle 1, granted in cycle 1; beats in cycles 2–5; way_we in cycle 6; req_ready high again in cycle 7.
  - Minimum 7 cycles request-to-ready.
- Address bits [1:0] are ignored.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W, INDEX_W, OFFSET_W=4, BEAT_W, BEATS, LINE_W.
  - Enum refill_state_t {IDLE,REQ,RECV,WRITE}.
  - Functions get_index(addr) and get_word_off(addr).
  - The data way and the controller import the same constants.
- No sub-module; the FSM, counter and line buffer fit in one module.

Test Plan:
- Request addr=0x0000_1238, grant in cycle 1, beats 0xA0,0xA1,0xA2,0xA3 (last on 4th) -> mem_rd_addr=0x1230; crit_valid with crit_word=0xA2 on 3rd beat; one-cycle way_we with windex=0x23, wdata=0x000000A3_000000A2_000000A1_000000A0; refill_done coincident; proto_err=0.
- Grant delayed 5 cycles, beats with random 0–3 cycle gaps, request addr=0x0000_FF04 -> mem_rd_req held stable until grant; windex=0xF0; crit_word = beat 1; line is correct.
- req_valid held high during RECV with a different address -> req_ready=0; the second request is ignored until IDLE, then accepted; the first line is written to the first index only.
- rst asserted during RECV after 2 beats -> the next cycle is IDLE with all outputs 0 except req_ready=1; no way_we ever; a following refill produces a clean line with no stale beat data.
- mem_rlast asserted on beat 2 -> proto_err=1 and sticky; the FSM still writes after 4 beats; proto_err is cleared only by rst.
- mem_rvalid pulses in IDLE and in REQ before the grant -> ignored; the beat counter stays 0.
